tlc_sensor_conditioner: RTL and testbench

- Upstream stage of the traffic light controller FSM; produces its S1/S2/S3 sensor inputs.
- Takes raw, asynchronous, bouncy vehicle-detector loop signals D1..D3 and synchronizes and debounces each one.
- Latches a vehicle request per approach.
- Clears that request once the FSM shows GREEN on the matching light (L1..L3 fed back).

---
 rtl/tlc_pkg.sv | 23 ++
 rtl/tlc_debounce.sv | 94 +++++++++
 rtl/tlc_sensor_conditioner.sv | 124 ++++++++++++
 tb/tb_tlc_sensor_conditioner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared types for the traffic light controller and its sensor conditioner
// Contents:
//   light_t        light state encoding shared with the controller FSM
//   db_state_t     per-channel debounce state
//   NUM_APPROACHES number of approaches (detectors / lights)
package tlc_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    LOW  = 2'b00,
    RISE = 2'b01,
    HIGH = 2'b10,
    FALL = 2'b11
  } db_state_t;

  localparam int NUM_APPROACHES = 3;

endpackage

// File: rtl/tlc_debounce.sv
// rtl/tlc_debounce.sv - two-flop synchronizer plus debounce FSM for one detector loop
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   raw  raw detector level, asynchronous to clk
//   det  debounced level, registered
module tlc_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic det
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             meta;
  logic             sync;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Nothing but these two flops may see raw.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Saturating increment: the count never wraps past the threshold.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      det   <= 1'b0;
    end else begin
      case (state)
        LOW: begin
          if (sync) begin
            state <= RISE;
            cnt   <= CNT_ONE;
          end
        end
        RISE: begin
          if (!sync) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt_inc == CNT_MAX) begin
            state <= HIGH;
            cnt   <= '0;
            det   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HIGH: begin
          if (!sync) begin
            state <= FALL;
            cnt   <= CNT_ONE;
          end
        end
        FALL: begin
          if (sync) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt_inc == CNT_MAX) begin
            state <= LOW;
            cnt   <= '0;
            det   <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
          det   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tlc_sensor_conditioner.sv
// rtl/tlc_sensor_conditioner.sv - debounced, latched vehicle requests S1..S3 for the controller FSM
// Optional feature macro: TLC_STUCK_DETECT_EN (stuck-detector flagging, adds Fault port)
// Ports:
//   Clock     system clock
//   Reset     asynchronous active-high reset
//   D1..D3    raw detector loops, asynchronous to Clock
//   L1..L3    light states fed back from the controller FSM
//   S1..S3    registered conditioned requests
//   Fault     per-approach stuck flag (TLC_STUCK_DETECT_EN only)
module tlc_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef TLC_STUCK_DETECT_EN
  , parameter int STUCK_CYCLES = 1000
`endif
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  light_t     L1,
  input  light_t     L2,
  input  light_t     L3,
  output logic       S1,
  output logic       S2,
  output logic       S3
`ifdef TLC_STUCK_DETECT_EN
  , output logic [2:0] Fault
`endif
);

  localparam int N = NUM_APPROACHES;

  logic [N-1:0] raw;
  logic [N-1:0] det;
  logic [N-1:0] det_q;
  logic [N-1:0] green;
  logic [N-1:0] req;
  logic [N-1:0] req_next;
  logic [N-1:0] level;
  logic [N-1:0] s_q;

  assign raw   = {D3, D2, D1};
  assign green = {L3 == GREEN, L2 == GREEN, L1 == GREEN};

  for (genvar g = 0; g < N; g++) begin : g_db
    tlc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk(Clock),
      .rst(Reset),
      .raw(raw[g]),
      .det(det[g])
    );
  end

  // A green light means the approach is being served, so clear beats a
  // simultaneous rising edge; a still-present vehicle keeps S up via det.
  always_comb begin
    req_next = req;
    for (int i = 0; i < N; i++) begin
      if (green[i]) begin
        req_next[i] = 1'b0;
      end else if (det[i] && !det_q[i]) begin
        req_next[i] = 1'b1;
      end
    end
  end

`ifdef TLC_STUCK_DETECT_EN
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);
  localparam logic [STK_W-1:0] STK_ONE = STK_W'(1);

  logic [STK_W-1:0] stuck_cnt [N];
  logic [N-1:0]     fault;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        stuck_cnt[i] <= '0;
      end
      fault <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!det[i]) begin
          stuck_cnt[i] <= '0;
          fault[i]     <= 1'b0;
        end else if (stuck_cnt[i] != STK_MAX) begin
          stuck_cnt[i] <= stuck_cnt[i] + STK_ONE;
          if (stuck_cnt[i] + STK_ONE == STK_MAX) begin
            fault[i] <= 1'b1;
          end
        end
      end
    end
  end

  // A stuck loop can no longer hold its request up by level alone.
  assign level = det & ~fault;
  assign Fault = fault;
`else
  assign level = det;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      det_q <= '0;
      req   <= '0;
      s_q   <= '0;
    end else begin
      det_q <= det;
      req   <= req_next;
      s_q   <= req_next | level;
    end
  end

  assign S1 = s_q[0];
  assign S2 = s_q[1];
  assign S3 = s_q[2];

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// tb/tb_tlc_sensor_conditioner.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_tlc_sensor_conditioner;
  import tlc_pkg::*;

  localparam int DB = 4;
`ifdef TLC_STUCK_DETECT_EN
  localparam int STK = 20;
`endif

  logic   Clock = 1'b0;
  logic   Reset = 1'b1;
  logic   D1 = 1'b0, D2 = 1'b0, D3 = 1'b0;
  light_t L1 = RED, L2 = RED, L3 = RED;
  logic   S1, S2, S3;
`ifdef TLC_STUCK_DETECT_EN
  logic [2:0] Fault;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  tlc_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DB)
`ifdef TLC_STUCK_DETECT_EN
    , .STUCK_CYCLES(STK)
`endif
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .D1(D1),
    .D2(D2),
    .D3(D3),
    .L1(L1),
    .L2(L2),
    .L3(L3),
    .S1(S1),
    .S2(S2),
    .S3(S3)
`ifdef TLC_STUCK_DETECT_EN
    , .Fault(Fault)
`endif
  );

  // Reference model: det flips once the last DB synchronized samples all
  // disagree with it; sync is the raw sample delayed by two edges.
  bit samp [3][$];
  bit m_det [3];
  bit m_det_prev [3];
  bit m_req [3];
  bit m_fault [3];
  int m_run [3];
  bit [2:0] m_s;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      samp[i].delete();
      for (int j = 0; j < DB + 2; j++) samp[i].push_back(1'b0);
      m_det[i] = 0; m_det_prev[i] = 0; m_req[i] = 0; m_fault[i] = 0; m_run[i] = 0;
    end
    m_s = '0;
  endfunction

  function automatic void model_edge(input bit [2:0] d, input light_t a, input light_t b, input light_t c);
    light_t l [3];
    l[0] = a; l[1] = b; l[2] = c;
    for (int i = 0; i < 3; i++) begin
      bit rise, req, all_flip;
      int sz;
      samp[i].push_back(d[i]);
      void'(samp[i].pop_front());
      sz = samp[i].size();
      rise = m_det[i] && !m_det_prev[i];
      req = (l[i] == GREEN) ? 1'b0 : (rise ? 1'b1 : m_req[i]);
      m_s[i] = req | (m_det[i] & !m_fault[i]);
`ifdef TLC_STUCK_DETECT_EN
      if (m_det[i]) begin
        if (m_run[i] < STK) m_run[i]++;
        m_fault[i] = (m_run[i] >= STK);
      end else begin
        m_run[i] = 0;
        m_fault[i] = 0;
      end
`endif
      all_flip = 1;
      for (int j = 0; j < DB; j++) begin
        if (samp[i][sz - 3 - j] == m_det[i]) all_flip = 0;
      end
      m_det_prev[i] = m_det[i];
      if (all_flip) m_det[i] = !m_det[i];
      m_req[i] = req;
    end
  endfunction

  task automatic expect_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit [2:0] d, input light_t a, input light_t b, input light_t c);
    @(negedge Clock);
    Reset = rst; D1 = d[0]; D2 = d[1]; D3 = d[2];
    L1 = a; L2 = b; L3 = c;
    @(posedge Clock);
    #1;
    if (rst) model_reset();
    else model_edge(d, a, b, c);
    n_cmp++;
    if ({S3, S2, S1} !== m_s) begin
      n_bad++;
      $display("FAIL model_s at %0t: got %b want %b", $time, {S3, S2, S1}, m_s);
    end
`ifdef TLC_STUCK_DETECT_EN
    n_cmp++;
    if (Fault !== {m_fault[2], m_fault[1], m_fault[0]}) begin
      n_bad++;
      $display("FAIL model_fault at %0t: got %b want %b", $time, Fault,
               {m_fault[2], m_fault[1], m_fault[0]});
    end
`endif
  endtask

  typedef struct {
    bit       rst;
    bit [2:0] d;
    light_t   l1, l2, l3;
    bit [2:0] s;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input bit [2:0] d, input bit [2:0] s, input int n);
    vec_t v;
    v.rst = rst; v.d = d; v.l1 = RED; v.l2 = RED; v.l3 = RED; v.s = s;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  function automatic light_t rand_light();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return GREEN;
    if (r <= 2) return YELLOW;
    return RED;
  endfunction

  initial begin
    bit [2:0] d;
    int slow;

    // Reset with all loops active, then clean rise reaching S at edge 7.
    add(1, 3'b111, 3'b000, 2);
    add(0, 3'b111, 3'b000, 6);
    add(0, 3'b111, 3'b111, 3);
    // Two-cycle glitch on D1 never reaches S1.
    add(1, 3'b000, 3'b000, 1);
    add(0, 3'b001, 3'b000, 2);
    add(0, 3'b000, 3'b000, 10);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].d, tbl[i].l1, tbl[i].l2, tbl[i].l3);
      n_cmp++;
      if ({S3, S2, S1} !== tbl[i].s) begin
        n_bad++;
        $display("FAIL table[%0d]: got %b want %b", i, {S3, S2, S1}, tbl[i].s);
      end
    end

    // D2 pulse of 5 cycles latches; one green cycle clears it.
    step(1, 3'b000, RED, RED, RED);
    for (int e = 1; e <= 15; e++) begin
      step(0, (e <= 5) ? 3'b010 : 3'b000, RED, RED, RED);
      if (e == 6) expect_bit("s2_pulse_e6", S2, 1'b0);
      if (e == 7) expect_bit("s2_pulse_e7", S2, 1'b1);
      if (e == 15) expect_bit("s2_latched", S2, 1'b1);
    end
    step(0, 3'b000, RED, GREEN, RED);
    expect_bit("s2_green_clear", S2, 1'b0);
    step(0, 3'b000, RED, RED, RED);
    expect_bit("s2_stays_clear", S2, 1'b0);

    // D3 held with L3 green: S3 follows det only.
    step(1, 3'b000, RED, RED, RED);
    for (int e = 1; e <= 10; e++) begin
      step(0, 3'b100, RED, RED, GREEN);
      if (e == 6) expect_bit("s3_green_e6", S3, 1'b0);
      if (e == 7) expect_bit("s3_green_e7", S3, 1'b1);
    end
    for (int e = 1; e <= 7; e++) begin
      step(0, 3'b000, RED, RED, RED);
      if (e == 6) expect_bit("s3_fall_e6", S3, 1'b1);
      if (e == 7) expect_bit("s3_fall_e7", S3, 1'b0);
    end

    // Green on the very cycle req1 would be set: clear wins.
    step(1, 3'b000, RED, RED, RED);
    for (int e = 1; e <= 10; e++) begin
      step(0, 3'b001, (e == 7) ? GREEN : RED, RED, RED);
      if (e == 7) expect_bit("s1_setclr_e7", S1, 1'b1);
      if (e == 10) expect_bit("s1_setclr_e10", S1, 1'b1);
    end
    for (int e = 1; e <= 8; e++) begin
      step(0, 3'b000, RED, RED, RED);
      if (e == 6) expect_bit("s1_setclr_fall_e6", S1, 1'b1);
      if (e == 8) expect_bit("s1_setclr_fall_e8", S1, 1'b0);
    end

`ifdef TLC_STUCK_DETECT_EN
    step(1, 3'b000, RED, RED, RED);
    for (int e = 1; e <= 30; e++) begin
      step(0, 3'b001, GREEN, RED, RED);
      if (e == 25) expect_bit("fault_e25", Fault[0], 1'b0);
      if (e == 26) expect_bit("fault_e26", Fault[0], 1'b1);
      if (e == 26) expect_bit("stuck_s1_e26", S1, 1'b1);
      if (e == 27) expect_bit("stuck_s1_e27", S1, 1'b0);
    end
    for (int e = 1; e <= 8; e++) begin
      step(0, 3'b000, GREEN, RED, RED);
      if (e == 6) expect_bit("fault_hold_e6", Fault[0], 1'b1);
      if (e == 7) expect_bit("fault_clear_e7", Fault[0], 1'b0);
    end
`endif

    // Randomized traffic against the model.
    step(1, 3'b000, RED, RED, RED);
    d = 3'b000;
    slow = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 64 == 0) slow = $urandom_range(0, 1);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, slow ? 40 : 3) == 0) d[i] = ~d[i];
      end
      step(($urandom_range(0, 499) == 0), d, rand_light(), rand_light(), rand_light());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
